// File: rtl/pool_pkg.sv
// Shared sizing helpers and sample type for the max-pool / ReLU stream stage.
package pool_pkg;

  localparam int SAMPLE_W = 16;
  localparam int LEN_DEF  = 39;
  localparam int P_DEF    = 3;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  // Width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int OUTS_PER_FRAME = ceil_div(LEN_DEF, P_DEF);

  typedef logic signed [SAMPLE_W-1:0] sample_t;

endpackage

// File: rtl/pool_out_fifo.sv
// Synchronous output FIFO for pooled results; head is readable combinationally.
module pool_out_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          wr_en;
  logic          rd_en;

  assign wr_en = push && !full;
  assign rd_en = pop && !empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_data;
  end

  assign pop_data = mem[rd_ptr];
  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);

endmodule

// File: rtl/maxpool_relu_stream.sv
// Streaming 1-D max-pool with optional ReLU; pooled values queue in a small FIFO.
module maxpool_relu_stream
  import pool_pkg::*;
#(
  parameter int T     = SAMPLE_W,
  parameter int LEN   = LEN_DEF,
  parameter int P     = P_DEF,
  parameter int RELU  = 1,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [T-1:0] s_data_in_x,
  input  logic         s_valid_x,
  output logic         s_ready_x,
  output logic [T-1:0] m_data_out_y,
  output logic         m_valid_y,
  input  logic         m_ready_y
);
  localparam int WIN_W = cnt_w(P);
  localparam int FRM_W = cnt_w(LEN);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(P - 1);
  localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(LEN - 1);

  function automatic logic signed [T-1:0] smax(input logic signed [T-1:0] a,
                                               input logic signed [T-1:0] b);
    return (b > a) ? b : a;
  endfunction

  function automatic logic signed [T-1:0] relu_clamp(input logic signed [T-1:0] v);
    if (RELU != 0 && v < 0) return '0;
    return v;
  endfunction

  logic [WIN_W-1:0]    win_cnt;
  logic [FRM_W-1:0]    frm_cnt;
  logic signed [T-1:0] acc_p1;

  logic signed [T-1:0] x_p0;
  logic signed [T-1:0] max_p0;
  logic signed [T-1:0] res_p0;
  logic                vld_p0;
  logic                frm_end_p0;
  logic                close_p0;

  logic [T-1:0]        fifo_head;
  logic                fifo_full;
  logic                fifo_empty;
  logic [CNT_W-1:0]    fifo_count;
  logic                pop;

  // Stage p0: accepted sample folded into the running window maximum.
  assign x_p0       = $signed(s_data_in_x);
  assign vld_p0     = s_valid_x && s_ready_x;
  assign max_p0     = (win_cnt == '0) ? x_p0 : smax(acc_p1, x_p0);
  assign frm_end_p0 = (frm_cnt == FRM_LAST);
  assign close_p0   = vld_p0 && ((win_cnt == WIN_LAST) || frm_end_p0);
  assign res_p0     = relu_clamp(max_p0);

  // Stage p1: window state; a closing sample also ends the window, so windows never straddle frames.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_p1  <= '0;
      win_cnt <= '0;
      frm_cnt <= '0;
    end else if (vld_p0) begin
      acc_p1  <= max_p0;
      win_cnt <= close_p0 ? '0 : win_cnt + WIN_W'(1);
      frm_cnt <= frm_end_p0 ? '0 : frm_cnt + FRM_W'(1);
    end
  end

  assign pop = m_valid_y && m_ready_y;

  pool_out_fifo #(
    .W     (T),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (close_p0),
    .push_data (res_p0),
    .pop       (pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Ready depends only on registered FIFO occupancy, never on m_ready_y.
  assign s_ready_x    = !fifo_full;
  assign m_valid_y    = (fifo_count != '0);
  assign m_data_out_y = fifo_empty ? '0 : fifo_head;

endmodule
